nibble_serial_adder: RTL and testbench

//   Multi-cycle wide adder. Latches two NIBBLES*4-bit operands and a carry-in,

---
 rtl/nibble_serial_adder.sv | 98 +++++++++
 tb/tb_nibble_serial_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder that reuses one 4-bit full adder, one nibble per clock
//   fulladd4 ports: a, b (nibble operands), c_in, sum, c_out, c3 (carry into bit 3)
//   nibble_serial_adder ports: clk, reset (sync, active-high), start, a_in, b_in, c_in,
//   busy, done, sum_out, c_out, overflow
module fulladd4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       c3
);
  logic [4:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c_out = c[4];
  assign c3    = c[3];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  input  logic                   c_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum_out,
  output logic                   c_out,
  output logic                   overflow
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [W-1:0] a_q, b_q, sum_q;
  logic carry_q, c_out_q, ovf_q;
  logic [IW+1:0] base;
  logic last;
  logic [3:0] fa_sum;
  logic fa_co, fa_c3;
  assign base = {idx_q, 2'b00};
  assign last = idx_q == IW'(NIBBLES - 1);
  fulladd4 u_fa (
    .a    (a_q[base+:4]),
    .b    (b_q[base+:4]),
    .c_in (carry_q),
    .sum  (fa_sum),
    .c_out(fa_co),
    .c3   (fa_c3)
  );
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN)  : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        a_q     <= a_in;
        b_q     <= b_in;
        carry_q <= c_in;
        idx_q   <= '0;
      end
      if (state_q == RUN) begin
        sum_q[base+:4] <= fa_sum;
        carry_q        <= fa_co;
        idx_q          <= idx_q + 1'b1;
        // MSB nibble: c3 is the carry into bit W-1, needed for signed overflow
        if (last) begin
          c_out_q <= fa_co;
          ovf_q   <= fa_c3 ^ fa_co;
        end
      end
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign sum_out  = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: table-driven and scoreboard checks for the serial adder
module tb_nibble_serial_adder;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic [15:0] a_in = 0, b_in = 0;
  logic c_in = 0;
  logic busy, done, c_out, overflow;
  logic [15:0] sum_out;
  logic s1_start = 0;
  logic [3:0] s1_a = 0, s1_b = 0;
  logic s1_ci = 0;
  logic s1_busy, s1_done, s1_co, s1_ov;
  logic [3:0] s1_sum;
  int pass = 0, total = 0;
  exp_t sb[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  nibble_serial_adder #(.NIBBLES(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .busy(busy), .done(done), .sum_out(sum_out), .c_out(c_out), .overflow(overflow)
  );
  nibble_serial_adder #(.NIBBLES(1)) u1 (
    .clk(clk), .reset(reset), .start(s1_start), .a_in(s1_a), .b_in(s1_b), .c_in(s1_ci),
    .busy(s1_busy), .done(s1_done), .sum_out(s1_sum), .c_out(s1_co), .overflow(s1_ov)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass++;
  endtask
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic ci);
    exp_t e;
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b} + {16'b0, ci};
    e.s  = r[15:0];
    e.co = r[16];
    e.ov = (a[15] == b[15]) && (r[15] != a[15]);
    sb.push_back(e);
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    exp_t e;
    while (!done && n < 20) begin
      chk({name, "_busy"}, busy, 1);
      tick();
      n++;
    end
    chk({name, "_latency"}, n, 4);
    e = sb.pop_front();
    chk({name, "_sum"}, sum_out, e.s);
    chk({name, "_cout"}, c_out, e.co);
    chk({name, "_ovf"}, overflow, e.ov);
    chk({name, "_busy_done"}, busy, 1);
    tick();
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_idle"}, busy, 0);
    chk({name, "_hold"}, sum_out, e.s);
  endtask
  task automatic op4(input string name, input logic [15:0] a, input logic [15:0] b, input logic ci);
    push(a, b, ci);
    start = 1; a_in = a; b_in = b; c_in = ci;
    tick();
    start = 0; a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom);
    wait_done(name);
  endtask
  initial begin
    tbl[0] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tick(); tick();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst1_busy", s1_busy, 0);
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      start = 1; a_in = tbl[i].a; b_in = tbl[i].b; c_in = tbl[i].ci;
      e.s = tbl[i].s; e.co = tbl[i].co; e.ov = tbl[i].ov;
      sb.push_back(e);
      tick();
      start = 0; a_in = 16'($urandom); b_in = 16'($urandom);
      wait_done($sformatf("vec%0d", i));
    end
    for (int i = 0; i < 10; i++)
      op4($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));
    push(16'h1111, 16'h2222, 1'b0);
    start = 1; a_in = 16'h1111; b_in = 16'h2222; c_in = 0;
    tick();
    start = 0;
    tick();
    start = 1; a_in = 16'hFFFF; b_in = 16'hFFFF; c_in = 1;
    tick();
    start = 0;
    begin
      int n = 2;
      exp_t e;
      while (!done && n < 20) begin tick(); n++; end
      chk("ignore_latency", n, 4);
      e = sb.pop_front();
      chk("ignore_sum", sum_out, e.s);
      chk("ignore_cout", c_out, e.co);
      start = 1; a_in = 16'hAAAA; b_in = 16'h5555; c_in = 1;
      tick();
      start = 0;
      chk("done_start_ignored", busy, 0);
      chk("done_start_sum", sum_out, e.s);
    end
    op4("b2b", 16'h0F0F, 16'h0101, 1'b1);
    start = 1; a_in = 16'h1234; b_in = 16'h1111; c_in = 0;
    tick();
    start = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum_out, 0);
    chk("abort_cout", c_out, 0);
    chk("abort_ovf", overflow, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done || busy) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    op4("post_abort", 16'h7000, 16'h1000, 1'b0);
    s1_start = 1; s1_a = 4'hF; s1_b = 4'h1; s1_ci = 1;
    tick();
    s1_start = 0; s1_a = 4'h0; s1_b = 4'h0; s1_ci = 0;
    chk("n1_busy", s1_busy, 1);
    chk("n1_done_early", s1_done, 0);
    tick();
    chk("n1_done", s1_done, 1);
    chk("n1_sum", s1_sum, 4'h1);
    chk("n1_cout", s1_co, 1);
    chk("n1_ovf", s1_ov, 0);
    tick();
    chk("n1_idle", s1_busy, 0);
    s1_start = 1; s1_a = 4'h7; s1_b = 4'h1; s1_ci = 0;
    tick();
    s1_start = 0;
    tick();
    chk("n1b_done", s1_done, 1);
    chk("n1b_sum", s1_sum, 4'h8);
    chk("n1b_cout", s1_co, 0);
    chk("n1b_ovf", s1_ov, 1);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
